// File: rtl/fw_loader.sv
// fw_loader: streams a firmware image into memory while holding the CPU in
// reset. Optionally plants the load address in the reset vector, then keeps
// the CPU in reset for a fixed settle time before releasing it.
//
// Ports
//   clk, reset_n          clock and synchronous active-low reset
//   start, base_addr      load request and image destination address
//   s_valid/s_data/s_last byte stream in, s_ready back-pressure out
//   mem_we/mem_addr/mem_din  single-byte memory write port
//   cpu_reset_n           CPU reset, low from start until the hold expires
//   busy, done, err       load status (err = address ran past all-ones)
//   byte_count            stream bytes accepted in the current load
//
// State  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | accepting stream bytes, one memory write per handshake
// VEC_LO | writing base_addr low byte to VECTOR_ADDR
// VEC_HI | writing base_addr high byte to VECTOR_ADDR+1
// HOLD   | CPU still in reset for HOLD_CYCLES cycles
// RUN    | CPU released, load complete
// ERR    | image ran off the top of the address space
//
// HOLD_CYCLES is expected to be at least 1.
module fw_loader #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    REG_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR  = 16'hFFFC,
  parameter bit                    WRITE_VECTOR = 1'b1,
  parameter int                    HOLD_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  s_valid,
  input  logic [REG_WIDTH-1:0]  s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, VEC_LO, VEC_HI, HOLD, RUN, ERR
  } state_t;

  localparam int TW = $clog2(HOLD_CYCLES + 2);
  // Counter counts down to zero inclusive, so load one less than the length.
  localparam logic [TW-1:0] HOLD_INIT = TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [TW-1:0]         hold_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      base_q      <= '0;
      hold_cnt    <= '0;
      s_ready     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      byte_count  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            ptr         <= base_addr;
            base_q      <= base_addr;
            byte_count  <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            cpu_reset_n <= 1'b0;
            s_ready     <= 1'b1;
            state       <= LOAD;
          end
        end

        LOAD: begin
          if (s_valid && s_ready) begin
            mem_we     <= 1'b1;
            mem_addr   <= ptr;
            mem_din    <= s_data;
            ptr        <= ptr + 1'b1;
            byte_count <= byte_count + 1'b1;
            if (s_last) begin
              // Last byte wins over overflow: landing on all-ones is legal.
              s_ready  <= 1'b0;
              hold_cnt <= HOLD_INIT;
              if (WRITE_VECTOR) state <= VEC_LO;
              else              state <= HOLD;
            end else if (ptr == {ADDR_WIDTH{1'b1}}) begin
              s_ready <= 1'b0;
              err     <= 1'b1;
              busy    <= 1'b0;
              state   <= ERR;
            end
          end
        end

        VEC_LO: begin
          mem_we   <= 1'b1;
          mem_addr <= VECTOR_ADDR;
          mem_din  <= base_q[REG_WIDTH-1:0];
          state    <= VEC_HI;
        end

        VEC_HI: begin
          mem_we   <= 1'b1;
          mem_addr <= VECTOR_ADDR + 1'b1;
          mem_din  <= base_q[2*REG_WIDTH-1:REG_WIDTH];
          hold_cnt <= HOLD_INIT;
          state    <= HOLD;
        end

        HOLD: begin
          if (hold_cnt == '0) begin
            cpu_reset_n <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= RUN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
